// File: rtl/graphics_memory_arbiter.sv
// ---------------------------------------------------------------------------
// graphics_memory_arbiter
//
// Shares the CPU-side port of the dual-port graphics memory between the CPU
// data path and the DMA/blit engine. One access is granted per cycle. The CPU
// wins a conflict unless the DMA side has already waited through STARVE_LIMIT
// consecutive CPU grants. Read data comes back one cycle after the grant and
// is steered to the requester that issued the read.
//
// Parameters:
//   STARVE_LIMIT   consecutive CPU grants tolerated while DMA waits (1..15)
//
// Ports:
//   Clock, Reset                 clock; synchronous active-high reset
//   CpuReq/CpuWrite/CpuAddr/     CPU command, held stable until CpuGrant
//   CpuByteEnable/CpuWData
//   CpuGrant                     CPU command accepted this cycle
//   CpuRValid/CpuRData           CPU read return (one cycle after grant)
//   Dma*                         same set of signals for the DMA engine
//   MemAddress/MemByteEnable/    command to the memory, sampled at the edge
//   MemData/MemWriteEnable       that ends the grant cycle
//   MemQ                         registered memory read data
// ---------------------------------------------------------------------------
module graphics_memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CpuReq,
  input  logic        CpuWrite,
  input  logic [16:0] CpuAddr,
  input  logic [3:0]  CpuByteEnable,
  input  logic [31:0] CpuWData,
  output logic        CpuGrant,
  output logic        CpuRValid,
  output logic [31:0] CpuRData,
  input  logic        DmaReq,
  input  logic        DmaWrite,
  input  logic [16:0] DmaAddr,
  input  logic [3:0]  DmaByteEnable,
  input  logic [31:0] DmaWData,
  output logic        DmaGrant,
  output logic        DmaRValid,
  output logic [31:0] DmaRData,
  output logic [14:0] MemAddress,
  output logic [3:0]  MemByteEnable,
  output logic [31:0] MemData,
  output logic        MemWriteEnable,
  input  logic [31:0] MemQ
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starveCount;
  logic       readPending;
  logic       readOwnerDma;
  logic       cpuSel;
  logic       dmaSel;

  // The two byte-offset bits of each address never reach the word-wide memory.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{CpuAddr[1:0], DmaAddr[1:0]};

  // Grant select: DMA only wins a conflict once it has been starved to the limit.
  always_comb begin
    cpuSel = 1'b0;
    dmaSel = 1'b0;
    if (Reset) begin
      cpuSel = 1'b0;
      dmaSel = 1'b0;
    end else if (DmaReq && (!CpuReq || (starveCount == STARVE_MAX))) begin
      dmaSel = 1'b1;
    end else if (CpuReq) begin
      cpuSel = 1'b1;
    end else begin
      cpuSel = 1'b0;
      dmaSel = 1'b0;
    end
  end

  assign CpuGrant = cpuSel;
  assign DmaGrant = dmaSel;

  // Memory command mux: lines follow the granted requester, all zero when idle.
  always_comb begin
    MemAddress     = 15'd0;
    MemByteEnable  = 4'd0;
    MemData        = 32'd0;
    MemWriteEnable = 1'b0;
    if (cpuSel) begin
      MemAddress     = CpuAddr[16:2];
      MemByteEnable  = CpuWrite ? CpuByteEnable : 4'd0;
      MemData        = CpuWData;
      MemWriteEnable = CpuWrite;
    end else if (dmaSel) begin
      MemAddress     = DmaAddr[16:2];
      MemByteEnable  = DmaWrite ? DmaByteEnable : 4'd0;
      MemData        = DmaWData;
      MemWriteEnable = DmaWrite;
    end else begin
      MemAddress     = 15'd0;
      MemByteEnable  = 4'd0;
      MemData        = 32'd0;
      MemWriteEnable = 1'b0;
    end
  end

  // Starvation counter: counts CPU grants that DMA waited through, saturating.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      starveCount <= 4'd0;
    end else if (!DmaReq || dmaSel) begin
      starveCount <= 4'd0;
    end else if (cpuSel && (starveCount < STARVE_MAX)) begin
      starveCount <= starveCount + 4'd1;
    end else begin
      starveCount <= starveCount;
    end
  end

  // Read owner tracking: remembers who issued the read sampled at this edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      readPending  <= 1'b0;
      readOwnerDma <= 1'b0;
    end else begin
      readPending  <= (cpuSel && !CpuWrite) || (dmaSel && !DmaWrite);
      readOwnerDma <= dmaSel;
    end
  end

  // Read return steering; Reset in the return cycle wins over the return.
  always_comb begin
    CpuRValid = 1'b0;
    CpuRData  = 32'd0;
    DmaRValid = 1'b0;
    DmaRData  = 32'd0;
    if (readPending && !Reset) begin
      if (readOwnerDma) begin
        DmaRValid = 1'b1;
        DmaRData  = MemQ;
      end else begin
        CpuRValid = 1'b1;
        CpuRData  = MemQ;
      end
    end else begin
      CpuRValid = 1'b0;
      DmaRValid = 1'b0;
    end
  end

endmodule

// File: tb/tb_graphics_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_graphics_memory_arbiter
//
// Drives the arbiter with directed scenarios and then randomized traffic.
// A behavioural model (fairness counter, shadow memory, pending-read record)
// predicts every output each cycle; a small memory model supplies MemQ.
// ---------------------------------------------------------------------------
module tb_graphics_memory_arbiter;

  localparam int LIMIT = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWrite, DmaReq, DmaWrite;
  logic [16:0] CpuAddr, DmaAddr;
  logic [3:0]  CpuByteEnable, DmaByteEnable;
  logic [31:0] CpuWData, DmaWData;
  logic        CpuGrant, CpuRValid, DmaGrant, DmaRValid;
  logic [31:0] CpuRData, DmaRData;
  logic [14:0] MemAddress;
  logic [3:0]  MemByteEnable;
  logic [31:0] MemData;
  logic        MemWriteEnable;
  logic [31:0] MemQ = 32'd0;

  int tests = 0;
  int fails = 0;

  graphics_memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr),
    .CpuByteEnable(CpuByteEnable), .CpuWData(CpuWData),
    .CpuGrant(CpuGrant), .CpuRValid(CpuRValid), .CpuRData(CpuRData),
    .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaAddr(DmaAddr),
    .DmaByteEnable(DmaByteEnable), .DmaWData(DmaWData),
    .DmaGrant(DmaGrant), .DmaRValid(DmaRValid), .DmaRData(DmaRData),
    .MemAddress(MemAddress), .MemByteEnable(MemByteEnable),
    .MemData(MemData), .MemWriteEnable(MemWriteEnable), .MemQ(MemQ)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] initWord(logic [14:0] a);
    return 32'h5A000000 | {17'd0, a};
  endfunction

  function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment (produces MemQ) ----------------
  logic [31:0] envMem [0:32767];
  bit          envWritten [0:32767];

  function automatic logic [31:0] envRead(logic [14:0] a);
    return envWritten[a] ? envMem[a] : initWord(a);
  endfunction

  // Registered single-port memory, write-before-read on the same address.
  always @(posedge Clock) begin
    if (MemWriteEnable) begin
      envMem[MemAddress]     <= mergeBytes(envRead(MemAddress), MemData, MemByteEnable);
      envWritten[MemAddress] <= 1'b1;
    end
    MemQ <= MemWriteEnable ? mergeBytes(envRead(MemAddress), MemData, MemByteEnable)
                           : envRead(MemAddress);
  end

  // ---------------- behavioural reference model ----------------
  logic [31:0] refMem [0:32767];
  bit          refWritten [0:32767];
  int          waitedGrants = 0;   // CPU grants the waiting DMA has sat through
  bit          retDue = 1'b0;
  bit          retToDma = 1'b0;
  logic [31:0] retWord = 32'd0;
  bit          cpuG = 1'b0;
  bit          dmaG = 1'b0;

  function automatic logic [31:0] refRead(logic [14:0] a);
    return refWritten[a] ? refMem[a] : initWord(a);
  endfunction

  task automatic modelStep();
    bit eC, eD, eW;
    logic [14:0] eA;
    logic [3:0] eBE;
    logic [31:0] eWD;
    eC = 1'b0; eD = 1'b0; eW = 1'b0; eA = 15'd0; eBE = 4'd0; eWD = 32'd0;
    if (!Reset) begin
      eD = DmaReq && (!CpuReq || waitedGrants == LIMIT);
      eC = CpuReq && !eD;
    end
    if (eC) begin
      eW = CpuWrite; eA = CpuAddr[16:2]; eWD = CpuWData;
      eBE = CpuWrite ? CpuByteEnable : 4'd0;
    end else if (eD) begin
      eW = DmaWrite; eA = DmaAddr[16:2]; eWD = DmaWData;
      eBE = DmaWrite ? DmaByteEnable : 4'd0;
    end
    check("CpuGrant", {31'd0, CpuGrant}, {31'd0, eC});
    check("DmaGrant", {31'd0, DmaGrant}, {31'd0, eD});
    check("MemAddress", {17'd0, MemAddress}, {17'd0, eA});
    check("MemByteEnable", {28'd0, MemByteEnable}, {28'd0, eBE});
    check("MemData", MemData, (eC || eD) ? eWD : 32'd0);
    check("MemWriteEnable", {31'd0, MemWriteEnable}, {31'd0, eW});
    check("CpuRValid", {31'd0, CpuRValid}, {31'd0, !Reset && retDue && !retToDma});
    check("DmaRValid", {31'd0, DmaRValid}, {31'd0, !Reset && retDue && retToDma});
    check("CpuRData", CpuRData, (!Reset && retDue && !retToDma) ? retWord : 32'd0);
    check("DmaRData", DmaRData, (!Reset && retDue && retToDma) ? retWord : 32'd0);
    if (Reset) begin
      waitedGrants = 0;
      retDue = 1'b0;
    end else begin
      if (eD || !DmaReq) waitedGrants = 0;
      else if (eC && waitedGrants < LIMIT) waitedGrants = waitedGrants + 1;
      if (eW) begin
        refMem[eA] = mergeBytes(refRead(eA), eWD, eBE);
        refWritten[eA] = 1'b1;
      end
      retDue = (eC || eD) && !eW;
      retToDma = eD;
      retWord = refRead(eA);
    end
    cpuG = CpuGrant;
    dmaG = DmaGrant;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) modelStep();

  // ---------------- protocol assertions ----------------
  assert property (@(posedge Clock) disable iff (Reset)
    (CpuReq && !CpuGrant) |=> (CpuReq && $stable({CpuWrite, CpuAddr, CpuByteEnable, CpuWData})))
    else begin fails++; $display("FAIL cpuHold: CPU command changed before grant at %0t", $time); end

  assert property (@(posedge Clock) disable iff (Reset)
    (DmaReq && !DmaGrant) |=> (DmaReq && $stable({DmaWrite, DmaAddr, DmaByteEnable, DmaWData})))
    else begin fails++; $display("FAIL dmaHold: DMA command changed before grant at %0t", $time); end

  // ---------------- stimulus ----------------
  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic setCpu(logic req, logic wr, logic [16:0] a, logic [3:0] be, logic [31:0] d);
    CpuReq = req; CpuWrite = wr; CpuAddr = a; CpuByteEnable = be; CpuWData = d;
  endtask

  task automatic setDma(logic req, logic wr, logic [16:0] a, logic [3:0] be, logic [31:0] d);
    DmaReq = req; DmaWrite = wr; DmaAddr = a; DmaByteEnable = be; DmaWData = d;
  endtask

  task automatic randCpu();
    setCpu($urandom_range(9) < 6, 1'($urandom_range(1)),
           ($urandom_range(7) == 0) ? 17'($urandom) : 17'($urandom_range(63)),
           4'($urandom_range(15)), $urandom);
  endtask

  task automatic randDma();
    setDma($urandom_range(9) < 7, 1'($urandom_range(1)),
           ($urandom_range(7) == 0) ? 17'($urandom) : 17'($urandom_range(63)),
           4'($urandom_range(15)), $urandom);
  endtask

  initial begin
    logic [9:0] pat;
    logic [4:0] pat5;

    // Reset held 3 cycles with both requesting.
    Reset = 1'b1;
    setCpu(1'b1, 1'b0, 17'h00010, 4'hF, 32'h0);
    setDma(1'b1, 1'b1, 17'h1FFFC, 4'b0011, 32'hAABBCCDD);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("rstCpuGrant", {31'd0, CpuGrant}, 32'd0);
      check("rstDmaGrant", {31'd0, DmaGrant}, 32'd0);
      check("rstMemAll", {MemAddress, MemByteEnable, MemWriteEnable}, 32'd0);
      check("rstMemData", MemData, 32'd0);
      check("rstRValid", {30'd0, CpuRValid, DmaRValid}, 32'd0);
      check("rstRData", CpuRData | DmaRData, 32'd0);
      nextCycle();
    end
    Reset = 1'b0;

    // First cycle after release: CPU read of 0x00010 wins.
    @(negedge Clock);
    check("relCpuGrant", {31'd0, CpuGrant}, 32'd1);
    check("cpuRdAddr", {17'd0, MemAddress}, 32'd4);
    check("cpuRdWe", {31'd0, MemWriteEnable}, 32'd0);
    nextCycle();
    CpuReq = 1'b0;

    // DMA-only partial write; CPU read returns in the same cycle.
    @(negedge Clock);
    check("dmaWrGrant", {31'd0, DmaGrant}, 32'd1);
    check("dmaWrAddr", {17'd0, MemAddress}, 32'h7FFF);
    check("dmaWrBe", {28'd0, MemByteEnable}, 32'h3);
    check("dmaWrWe", {31'd0, MemWriteEnable}, 32'd1);
    check("dmaWrData", MemData, 32'hAABBCCDD);
    check("cpuRetValid", {31'd0, CpuRValid}, 32'd1);
    check("cpuRetData", CpuRData, 32'h5A000004);
    check("cpuRetDmaValid", {31'd0, DmaRValid}, 32'd0);
    nextCycle();
    DmaReq = 1'b0;
    @(negedge Clock);
    check("memLanes", envRead(15'h7FFF), 32'h5A00CCDD);
    nextCycle();

    // Both requesting reads continuously: C C C C D C C C C D.
    pat = 10'b1000010000;
    setCpu(1'b1, 1'b0, 17'($urandom_range(63)), 4'hF, 32'd0);
    setDma(1'b1, 1'b0, 17'($urandom_range(63)), 4'hF, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("seqCpuGrant", {31'd0, CpuGrant}, {31'd0, !pat[i]});
      check("seqDmaGrant", {31'd0, DmaGrant}, {31'd0, pat[i]});
      if (i == 5) begin
        check("seqDmaRet", {31'd0, DmaRValid}, 32'd1);
        check("seqDmaRetCpu", {31'd0, CpuRValid}, 32'd0);
      end
      nextCycle();
      if (pat[i]) DmaAddr = 17'($urandom_range(63));
      else CpuAddr = 17'($urandom_range(63));
    end
    DmaReq = 1'b0;
    @(negedge Clock);
    check("drainCpu", {31'd0, CpuGrant}, 32'd1);
    nextCycle();
    CpuReq = 1'b0;
    nextCycle();

    // Build up starvation, then reset right after a CPU read grant.
    setCpu(1'b1, 1'b0, 17'h00040, 4'hF, 32'd0);
    setDma(1'b1, 1'b0, 17'h00080, 4'hF, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("preRstCpu", {31'd0, CpuGrant}, 32'd1);
      nextCycle();
      CpuAddr = 17'h00044 + 17'(i * 4);
    end
    Reset = 1'b1;
    @(negedge Clock);
    check("rstRetSuppressed", {31'd0, CpuRValid}, 32'd0);
    check("rstNoGrant", {31'd0, CpuGrant | DmaGrant}, 32'd0);
    nextCycle();
    Reset = 1'b0;
    pat5 = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("postRstDma", {31'd0, DmaGrant}, {31'd0, pat5[i]});
      nextCycle();
      if (!pat5[i]) CpuAddr = 17'($urandom_range(63));
    end
    DmaReq = 1'b0;
    nextCycle();
    CpuReq = 1'b0;
    nextCycle();

    // Write then immediately read the same word.
    setCpu(1'b1, 1'b1, 17'h00020, 4'hF, 32'h12345678);
    @(negedge Clock);
    check("wrGrant", {31'd0, CpuGrant & MemWriteEnable}, 32'd1);
    check("wrAddr", {17'd0, MemAddress}, 32'd8);
    nextCycle();
    setCpu(1'b1, 1'b0, 17'h00020, 4'hF, 32'd0);
    @(negedge Clock);
    check("rdGrant", {31'd0, CpuGrant}, 32'd1);
    nextCycle();
    CpuReq = 1'b0;
    @(negedge Clock);
    check("rawValid", {31'd0, CpuRValid}, 32'd1);
    check("rawData", CpuRData, 32'h12345678);
    nextCycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(63) == 0);
      if (!CpuReq || cpuG) randCpu();
      if (!DmaReq || dmaG) randDma();
      nextCycle();
    end
    Reset = 1'b0;
    nextCycle();
    @(negedge Clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/graphics_memory_arbiter.md
# graphics_memory_arbiter

Arbitrates the single CPU-side port of the graphics memory between two requesters: the CPU data path and a DMA/blit engine that fills the frame buffer. It grants one access per cycle, drives the memory address, byte-enable, write-data and write-enable lines, and returns read data one cycle later to the requester that issued the read. The CPU has priority, with a bounded-starvation counter that guarantees the DMA requester forward progress. The GPU scan-out port on the other side of the dual-port memory is not touched by this block.

## Interface
- STARVE_LIMIT, 4: maximum consecutive CPU grants while DMA is waiting; range 1..15.
- Clock  in  1  clock; reset Reset, synchronous, active-high; clock Clock.
- Reset  in  1  synchronous, active-high.
- CpuReq  in  1  CPU access request; held until CpuGrant.
- CpuWrite  in  1  1 = write, 0 = read.
- CpuAddr  in  17  byte address; bits [16:2] select the word.
- CpuByteEnable  in  4  memory-order byte lanes; ignored for reads.
- CpuWData  in  32  write data, already lane-positioned.
- CpuGrant  out  1  request accepted this cycle.
- CpuRValid  out  1  CpuRData valid this cycle.
- CpuRData  out  32  read data.
- DmaReq, DmaWrite, DmaAddr, DmaByteEnable, DmaWData  in  1/1/17/4/32  same meaning for DMA.
- DmaGrant, DmaRValid  out  1  same meaning for DMA.
- DmaRData  out  32  read data.
- MemAddress  out  15  word address to the memory.
- MemByteEnable  out  4  byte enables.
- MemData  out  32  write data.
- MemWriteEnable  out  1  write strobe.
- MemQ  in  32  registered memory read data, valid the cycle after the address is sampled.

## Operation
- Grant select is combinational from the requests and the registered counter. At most one grant per cycle.
  - Only CpuReq: CPU granted.
  - Only DmaReq: DMA granted.
  - Both: DMA is granted if StarveCount == STARVE_LIMIT; otherwise CPU is granted.
- StarveCount is 4 bits, registered, 0 at reset.
  - Increments when CPU is granted while DmaReq = 1.
  - Clears on a DMA grant, or in any cycle DmaReq = 0.
  - Saturates at STARVE_LIMIT.
- Memory lines are driven from the granted requester:
  - MemAddress = Addr[16:2].
  - MemWriteEnable = Grant & Write.
  - MemByteEnable = Grant & Write ? ByteEnable : 0.
  - MemData = WData.
- With no grant, all memory outputs are 0.
- Read return uses a registered owner field {ReadPending, ReadOwner}, set on the granted-read edge.
  - Next cycle: the owner's RValid = 1 and its RData = MemQ.
  - The other requester's RData = 0.
- A write with ByteEnable = 0 is granted normally and changes no memory content.
- Requesters must hold Req, Write, Addr, ByteEnable and WData stable until granted. The bench checks this with an assertion.
- During Reset, no grant is issued and all memory outputs are 0.

## Timing
- Values after reset:
  - Grants, RValid and MemWriteEnable: 0.
  - RData and Mem* outputs: 0.
  - StarveCount: 0. ReadPending: 0.
- Grant latency is 0 cycles: the grant is asserted in the same cycle as Req when selected.
- Memory samples the command at the rising edge that ends the grant cycle.
- Read latency: granted in cycle N, RValid and RData in cycle N+1, one cycle wide.
- Back-to-back accesses are fully pipelined, one per cycle. A read in N+1 overlapping a return in N+1 is legal.
- Write then read of the same word in consecutive cycles returns the new data. This relies on memory write-before-read ordering on a single port.
- Reset asserted in cycle N+1 after a read granted in N suppresses RValid in N+1. Reset has priority over the return.
- Under continuous requests from both sides, the grant pattern repeats every STARVE_LIMIT+1 cycles: STARVE_LIMIT CPU grants, then 1 DMA grant.
- STARVE_LIMIT = 1 gives strict alternation, starting with CPU.

## Test plan
- Reset held 3 cycles with both requests asserted:
  - No grants; all outputs 0.
  - After release: CpuGrant in the first cycle.
- CPU-only read, CpuAddr = 0x00010:
  - CpuGrant = 1, MemAddress = 4, MemWriteEnable = 0 in the same cycle.
  - Next cycle: CpuRValid = 1 and CpuRData = MemQ; DmaRValid = 0.
- DMA-only write, DmaAddr = 0x1FFFC, ByteEnable = 4'b0011, WData = 0xAABBCCDD:
  - MemAddress = 0x7FFF, MemByteEnable = 0011, MemWriteEnable = 1.
  - Memory model shows only the low two lanes updated.
- Both requesting continuously, STARVE_LIMIT = 4, 10 cycles:
  - Grant sequence C C C C D C C C C D.
  - DMA reads return to DmaRData only.
- CPU read granted, Reset asserted the next cycle:
  - CpuRValid stays 0.
  - StarveCount is 0 after release.
- CPU write of 0x12345678 to word 8, CPU read of word 8 in the next cycle:
  - CpuRData = 0x12345678 one cycle after the read grant.
